// File: rtl/srai_kernel_launch_ctrl.sv
// AXI-Lite master sequencer: programs HLS kernel arguments, writes ap_start, polls ap_done
// and returns a status code plus the elapsed cycle count for each job.
module srai_kernel_launch_ctrl #(
    parameter int unsigned     P_AW       = 32,
    parameter logic [P_AW-1:0] P_BASE     = '0,
    parameter int unsigned     P_POLL_GAP = 16,
    parameter logic [31:0]     P_TIMEOUT  = 32'd1_000_000
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [63:0]     cmd_src,
    input  logic [63:0]     cmd_dst,
    input  logic [31:0]     cmd_len,
    output logic            sts_valid,
    input  logic            sts_ready,
    output logic [1:0]      sts_code,
    output logic [31:0]     sts_cycles,
    output logic            busy,
    output logic [P_AW-1:0] AXI_LITE_awaddr,
    output logic [2:0]      AXI_LITE_awprot,
    output logic            AXI_LITE_awvalid,
    input  logic            AXI_LITE_awready,
    output logic [31:0]     AXI_LITE_wdata,
    output logic [3:0]      AXI_LITE_wstrb,
    output logic            AXI_LITE_wvalid,
    input  logic            AXI_LITE_wready,
    input  logic [1:0]      AXI_LITE_bresp,
    input  logic            AXI_LITE_bvalid,
    output logic            AXI_LITE_bready,
    output logic [P_AW-1:0] AXI_LITE_araddr,
    output logic [2:0]      AXI_LITE_arprot,
    output logic            AXI_LITE_arvalid,
    input  logic            AXI_LITE_arready,
    input  logic [31:0]     AXI_LITE_rdata,
    input  logic [1:0]      AXI_LITE_rresp,
    input  logic            AXI_LITE_rvalid,
    output logic            AXI_LITE_rready
);
    localparam int unsigned KW = 3;
    localparam int unsigned CW = 32;
    localparam logic [KW-1:0] K_LAST = 3'd5;

    typedef enum logic [2:0] {IDLE, WR, WB, POLL_WAIT, RD_A, RD_R, STS} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [63:0]     src_r, src_nxt, dst_r, dst_nxt;
    logic [31:0]     len_r, len_nxt;
    logic            aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic [CW-1:0]   gap_cnt, gap_nxt, tmo_cnt, tmo_nxt, cyc_nxt;
    logic            cmd_ready_nxt, sts_valid_nxt, busy_nxt;
    logic [1:0]      code_nxt;
    logic            awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [P_AW-1:0] awaddr_nxt, araddr_nxt;
    logic [31:0]     wdata_nxt;
    logic            aw_fire, w_fire;
    logic            unused_rdata;

    assign AXI_LITE_awprot = 3'b000;
    assign AXI_LITE_arprot = 3'b000;
    assign AXI_LITE_wstrb  = 4'hF;
    assign unused_rdata    = ^{AXI_LITE_rdata[31:2], AXI_LITE_rdata[0]};
    assign aw_fire = AXI_LITE_awvalid && AXI_LITE_awready;
    assign w_fire  = AXI_LITE_wvalid && AXI_LITE_wready;

    // Argument register map: k0..k4 kernel arguments, k5 ap_start in the control register
    function automatic logic [7:0] reg_off(input logic [KW-1:0] idx);
        case (idx)
            3'd0:    return 8'h10;
            3'd1:    return 8'h14;
            3'd2:    return 8'h1C;
            3'd3:    return 8'h20;
            3'd4:    return 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] reg_data(input logic [KW-1:0] idx, input logic [63:0] s,
                                             input logic [63:0] d, input logic [31:0] l);
        case (idx)
            3'd0:    return s[31:0];
            3'd1:    return s[63:32];
            3'd2:    return d[31:0];
            3'd3:    return d[63:32];
            3'd4:    return l;
            default: return 32'h1;
        endcase
    endfunction

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        src_nxt       = src_r;
        dst_nxt       = dst_r;
        len_nxt       = len_r;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        gap_nxt       = gap_cnt;
        tmo_nxt       = tmo_cnt;
        cyc_nxt       = sts_cycles;
        cmd_ready_nxt = cmd_ready;
        sts_valid_nxt = sts_valid;
        code_nxt      = sts_code;
        awvalid_nxt   = AXI_LITE_awvalid;
        wvalid_nxt    = AXI_LITE_wvalid;
        bready_nxt    = AXI_LITE_bready;
        arvalid_nxt   = AXI_LITE_arvalid;
        rready_nxt    = AXI_LITE_rready;
        awaddr_nxt    = AXI_LITE_awaddr;
        araddr_nxt    = AXI_LITE_araddr;
        wdata_nxt     = AXI_LITE_wdata;

        // Elapsed and timeout counters run from ap_start acknowledge until ap_done is judged
        if (state == POLL_WAIT || state == RD_A || state == RD_R) begin
            if (sts_cycles != '1) cyc_nxt = sts_cycles + 32'd1;
            if (tmo_cnt != '1)    tmo_nxt = tmo_cnt + 32'd1;
        end

        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    src_nxt       = cmd_src;
                    dst_nxt       = cmd_dst;
                    len_nxt       = cmd_len;
                    k_nxt         = '0;
                    cmd_ready_nxt = 1'b0;
                    awvalid_nxt   = 1'b1;
                    wvalid_nxt    = 1'b1;
                    aw_done_nxt   = 1'b0;
                    w_done_nxt    = 1'b0;
                    awaddr_nxt    = P_BASE + P_AW'(reg_off(3'd0));
                    wdata_nxt     = cmd_src[31:0];
                    state_nxt     = WR;
                end
            end
            WR: begin
                if (aw_fire) begin
                    awvalid_nxt = 1'b0;
                    aw_done_nxt = 1'b1;
                end
                if (w_fire) begin
                    wvalid_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WB;
                end
            end
            WB: begin
                if (AXI_LITE_bvalid) begin
                    bready_nxt = 1'b0;
                    if (AXI_LITE_bresp != 2'b00) begin
                        code_nxt      = 2'b01;
                        sts_valid_nxt = 1'b1;
                        state_nxt     = STS;
                    end else if (k != K_LAST) begin
                        k_nxt       = k + 3'd1;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                        awaddr_nxt  = P_BASE + P_AW'(reg_off(k + 3'd1));
                        wdata_nxt   = reg_data(k + 3'd1, src_r, dst_r, len_r);
                        state_nxt   = WR;
                    end else begin
                        cyc_nxt   = '0;
                        tmo_nxt   = '0;
                        gap_nxt   = '0;
                        state_nxt = POLL_WAIT;
                    end
                end
            end
            POLL_WAIT: begin
                if (tmo_cnt >= P_TIMEOUT) begin
                    code_nxt      = 2'b11;
                    sts_valid_nxt = 1'b1;
                    state_nxt     = STS;
                end else if (gap_cnt == 32'(P_POLL_GAP - 1)) begin
                    arvalid_nxt = 1'b1;
                    araddr_nxt  = P_BASE;
                    state_nxt   = RD_A;
                end else begin
                    gap_nxt = gap_cnt + 32'd1;
                end
            end
            RD_A: begin
                if (AXI_LITE_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_R;
                end
            end
            RD_R: begin
                if (AXI_LITE_rvalid) begin
                    rready_nxt = 1'b0;
                    if (AXI_LITE_rresp != 2'b00) begin
                        code_nxt      = 2'b10;
                        sts_valid_nxt = 1'b1;
                        state_nxt     = STS;
                    end else if (AXI_LITE_rdata[1]) begin
                        code_nxt      = 2'b00;
                        sts_valid_nxt = 1'b1;
                        state_nxt     = STS;
                    end else begin
                        gap_nxt   = '0;
                        state_nxt = POLL_WAIT;
                    end
                end
            end
            STS: begin
                if (sts_ready) begin
                    sts_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= IDLE;
            k                <= '0;
            src_r            <= '0;
            dst_r            <= '0;
            len_r            <= '0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            gap_cnt          <= '0;
            tmo_cnt          <= '0;
            sts_cycles       <= '0;
            cmd_ready        <= 1'b0;
            sts_valid        <= 1'b0;
            sts_code         <= 2'b00;
            busy             <= 1'b0;
            AXI_LITE_awvalid <= 1'b0;
            AXI_LITE_wvalid  <= 1'b0;
            AXI_LITE_bready  <= 1'b0;
            AXI_LITE_arvalid <= 1'b0;
            AXI_LITE_rready  <= 1'b0;
            AXI_LITE_awaddr  <= '0;
            AXI_LITE_araddr  <= '0;
            AXI_LITE_wdata   <= '0;
        end else begin
            state            <= state_nxt;
            k                <= k_nxt;
            src_r            <= src_nxt;
            dst_r            <= dst_nxt;
            len_r            <= len_nxt;
            aw_done          <= aw_done_nxt;
            w_done           <= w_done_nxt;
            gap_cnt          <= gap_nxt;
            tmo_cnt          <= tmo_nxt;
            sts_cycles       <= cyc_nxt;
            cmd_ready        <= cmd_ready_nxt;
            sts_valid        <= sts_valid_nxt;
            sts_code         <= code_nxt;
            busy             <= busy_nxt;
            AXI_LITE_awvalid <= awvalid_nxt;
            AXI_LITE_wvalid  <= wvalid_nxt;
            AXI_LITE_bready  <= bready_nxt;
            AXI_LITE_arvalid <= arvalid_nxt;
            AXI_LITE_rready  <= rready_nxt;
            AXI_LITE_awaddr  <= awaddr_nxt;
            AXI_LITE_araddr  <= araddr_nxt;
            AXI_LITE_wdata   <= wdata_nxt;
        end
    end
endmodule
